manchester_frame_tx: RTL and testbench

MANCHESTER_FRAME_TX -- requirements
Module: manchester_frame_tx

---
 rtl/manchester_frame_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_manchester_frame_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: AXI-Stream words in, preamble + data + idle gap out on one serial line.
// Define MANCHESTER_FRAME_TX_IEEE_EN for IEEE 802.3 polarity (1 = low-then-high); default is G.E. Thomas.
module manchester_frame_tx #(
    parameter int                    DATA_WIDTH       = 8,
    parameter int                    HALF_BIT_CYCLES  = 1,
    parameter int                    PREAMBLE_WORDS   = 2,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_PATTERN = DATA_WIDTH'(8'h55),
    parameter int                    GAP_BITS         = 2,
    parameter int                    MSB_FIRST        = 1,
    parameter logic                  IDLE_LEVEL       = 1'b0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);
    localparam int GAP_CYCLES = GAP_BITS * 2 * HALF_BIT_CYCLES;
    localparam int HB_W       = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam int BIT_W      = $clog2(DATA_WIDTH);
    localparam int WRD_W      = (PREAMBLE_WORDS > 1) ? $clog2(PREAMBLE_WORDS) : 1;
    localparam int GAP_W      = $clog2(GAP_CYCLES);
    localparam int PRE_LAST   = (PREAMBLE_WORDS > 0) ? PREAMBLE_WORDS - 1 : 0;

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_GAP} state_t;

    state_t                state_r;
    logic [HB_W-1:0]       hb_cnt_r;
    logic                  phase_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [WRD_W-1:0]      word_cnt_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  shift_last_r;
    logic                  aborted_r;
    logic [DATA_WIDTH-1:0] hold_data_r;
    logic                  hold_last_r;
    logic                  hold_valid_r;
    logic                  tready_r;
    logic                  serial_r;
    logic                  busy_r;
    logic                  frame_done_r;
    logic                  underrun_r;

    logic                  accept_s;
    logic                  end_half_s;
    logic                  end_word_s;
    logic                  pre_last_s;
    logic                  gap_end_s;
    logic                  start_s;
    logic                  load_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST != 0) first_bit = w[DATA_WIDTH-1];
        else                first_bit = w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST != 0) shift_word = {w[DATA_WIDTH-2:0], 1'b0};
        else                shift_word = {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // Line level for a bit in its first (second_half=0) or second half.
    function automatic logic encode(input logic b, input logic second_half);
`ifdef MANCHESTER_FRAME_TX_IEEE_EN
        encode = ~(b ^ second_half);
`else
        encode = b ^ second_half;
`endif
    endfunction

    assign accept_s   = s_axis_tvalid && tready_r;
    assign end_half_s = (hb_cnt_r == HB_W'(HALF_BIT_CYCLES - 1));
    assign end_word_s = end_half_s && phase_r && (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));
    assign pre_last_s = (word_cnt_r == WRD_W'(PRE_LAST));
    assign gap_end_s  = (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
    assign shifted_s  = shift_word(shift_r);

    // Decide when a frame starts and when HOLD is consumed into the shifter.
    always_comb begin
        start_s = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = hold_valid_r;
                load_s  = hold_valid_r && (PREAMBLE_WORDS == 0);
            end
            ST_PREAMBLE: begin
                load_s = hold_valid_r && end_word_s && pre_last_s;
            end
            ST_DATA: begin
                load_s = hold_valid_r && end_word_s && !shift_last_r;
            end
            ST_GAP: begin
                start_s = hold_valid_r && gap_end_s;
                load_s  = hold_valid_r && gap_end_s && (PREAMBLE_WORDS == 0);
            end
            default: begin
                start_s = 1'b0;
                load_s  = 1'b0;
            end
        endcase
    end

    // One-deep input holding register; ready is registered and stays low until the first edge after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_data_r  <= '0;
            hold_last_r  <= 1'b0;
            hold_valid_r <= 1'b0;
            tready_r     <= 1'b0;
        end else if (accept_s) begin
            hold_data_r  <= s_axis_tdata;
            hold_last_r  <= s_axis_tlast;
            hold_valid_r <= 1'b1;
            tready_r     <= 1'b0;
        end else if (load_s) begin
            hold_valid_r <= 1'b0;
            tready_r     <= 1'b1;
        end else begin
            tready_r     <= !hold_valid_r;
        end
    end

    // Frame sequencer; counters always describe the half-bit currently on the line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= ST_IDLE;
            hb_cnt_r     <= '0;
            phase_r      <= 1'b0;
            bit_cnt_r    <= '0;
            word_cnt_r   <= '0;
            gap_cnt_r    <= '0;
            shift_r      <= '0;
            shift_last_r <= 1'b0;
            aborted_r    <= 1'b0;
            serial_r     <= IDLE_LEVEL;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            if (start_s) begin
                hb_cnt_r   <= '0;
                phase_r    <= 1'b0;
                bit_cnt_r  <= '0;
                word_cnt_r <= '0;
                gap_cnt_r  <= '0;
                aborted_r  <= 1'b0;
                busy_r     <= 1'b1;
                if (PREAMBLE_WORDS > 0) begin
                    state_r      <= ST_PREAMBLE;
                    shift_r      <= PREAMBLE_PATTERN;
                    shift_last_r <= 1'b0;
                    serial_r     <= encode(first_bit(PREAMBLE_PATTERN), 1'b0);
                end else begin
                    state_r      <= ST_DATA;
                    shift_r      <= hold_data_r;
                    shift_last_r <= hold_last_r;
                    serial_r     <= encode(first_bit(hold_data_r), 1'b0);
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        serial_r <= IDLE_LEVEL;
                        busy_r   <= 1'b0;
                    end
                    ST_PREAMBLE, ST_DATA: begin
                        if (!end_half_s) begin
                            hb_cnt_r <= hb_cnt_r + HB_W'(1);
                        end else if (!phase_r) begin
                            hb_cnt_r <= '0;
                            phase_r  <= 1'b1;
                            serial_r <= encode(first_bit(shift_r), 1'b1);
                        end else if (!end_word_s) begin
                            hb_cnt_r  <= '0;
                            phase_r   <= 1'b0;
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            shift_r   <= shifted_s;
                            serial_r  <= encode(first_bit(shifted_s), 1'b0);
                        end else begin
                            hb_cnt_r  <= '0;
                            phase_r   <= 1'b0;
                            bit_cnt_r <= '0;
                            if ((state_r == ST_PREAMBLE) && !pre_last_s) begin
                                word_cnt_r <= word_cnt_r + WRD_W'(1);
                                shift_r    <= PREAMBLE_PATTERN;
                                serial_r   <= encode(first_bit(PREAMBLE_PATTERN), 1'b0);
                            end else if (load_s) begin
                                state_r      <= ST_DATA;
                                shift_r      <= hold_data_r;
                                shift_last_r <= hold_last_r;
                                serial_r     <= encode(first_bit(hold_data_r), 1'b0);
                            end else begin
                                // Either a clean end of frame or starvation mid-frame.
                                state_r    <= ST_GAP;
                                gap_cnt_r  <= '0;
                                serial_r   <= IDLE_LEVEL;
                                underrun_r <= !((state_r == ST_DATA) && shift_last_r);
                                aborted_r  <= !((state_r == ST_DATA) && shift_last_r);
                            end
                        end
                    end
                    ST_GAP: begin
                        serial_r <= IDLE_LEVEL;
                        if (gap_end_s) begin
                            state_r   <= ST_IDLE;
                            gap_cnt_r <= '0;
                            busy_r    <= 1'b0;
                        end else begin
                            gap_cnt_r    <= gap_cnt_r + GAP_W'(1);
                            frame_done_r <= (gap_cnt_r == GAP_W'(GAP_CYCLES - 2)) && !aborted_r;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        serial_r <= IDLE_LEVEL;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign serial_out    = serial_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign underrun      = underrun_r;
endmodule

// File: tb/tb_manchester_frame_tx.sv
// Self-checking bench for manchester_frame_tx: table vectors, hand-written corner sequences and
// randomized frames compared against a half-bit-level reference model.
module tb_manchester_frame_tx;
    localparam int PRE  = 2;
    localparam int GAPC = 4;
`ifdef MANCHESTER_FRAME_TX_IEEE_EN
    localparam int IEEE = 1;
`else
    localparam int IEEE = 0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] tdata;
    logic       tvalid, tready, tlast, serial_out, busy, frame_done, underrun;
    logic [7:0] d2_tdata;
    logic       d2_tvalid, d2_tready, d2_tlast, d2_serial, d2_busy, d2_done, d2_under;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] halves;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] word_q[$];
    bit         last_q[$];
    int exp_line[$], exp_fd[$], exp_ur[$];
    int obs_line[$], obs_fd[$], obs_ur[$];
    int first_acc, first_busy, rdy_cnt;

    manchester_frame_tx dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
        .serial_out(serial_out), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    manchester_frame_tx #(.HALF_BIT_CYCLES(3), .MSB_FIRST(0), .PREAMBLE_WORDS(0)) dut2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(d2_tdata), .s_axis_tvalid(d2_tvalid), .s_axis_tready(d2_tready), .s_axis_tlast(d2_tlast),
        .serial_out(d2_serial), .busy(d2_busy), .frame_done(d2_done), .underrun(d2_under)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a bit is its first-half level then the opposite level, each for h cycles.
    function automatic void model_word(input int w, input int width, input int msb, input int h);
        for (int i = 0; i < width; i++) begin
            int b, first;
            b     = (msb != 0) ? ((w >> (width - 1 - i)) & 1) : ((w >> i) & 1);
            first = (IEEE != 0) ? 1 - b : b;
            for (int k = 0; k < 2 * h; k++) begin
                exp_line.push_back((k < h) ? first : 1 - first);
                exp_fd.push_back(0);
                exp_ur.push_back(0);
            end
        end
    endfunction

    function automatic void model_preamble();
        for (int p = 0; p < PRE; p++) model_word('h55, 8, 1, 1);
    endfunction

    function automatic void model_gap(input int cycles, input int aborted);
        for (int k = 0; k < cycles; k++) begin
            exp_line.push_back(0);
            exp_fd.push_back((aborted == 0 && k == cycles - 1) ? 1 : 0);
            exp_ur.push_back((aborted != 0 && k == 0) ? 1 : 0);
        end
    endfunction

    function automatic void clear_all();
        word_q.delete(); last_q.delete();
        exp_line.delete(); exp_fd.delete(); exp_ur.delete();
        obs_line.delete(); obs_fd.delete(); obs_ur.delete();
        rdy_cnt = 0;
    endfunction

    task automatic drive_all();
        int n;
        for (int i = 0; i < word_q.size(); i++) begin
            tdata  = word_q[i];
            tlast  = last_q[i];
            tvalid = 1'b1;
            n = 0;
            while (!tready && n < 400) begin
                @(negedge aclk);
                n++;
            end
            chk("accept_wait", int'(tready), 1);
            if (i == 0) first_acc = cyc + 1;
            @(negedge aclk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic capture();
        int n;
        n = 0;
        while (!busy && n < 400) begin
            @(negedge aclk);
            n++;
        end
        first_busy = cyc;
        while (busy && n < 3000) begin
            obs_line.push_back(int'(serial_out));
            obs_fd.push_back(int'(frame_done));
            obs_ur.push_back(int'(underrun));
            if (tready) rdy_cnt++;
            @(negedge aclk);
            n++;
        end
        chk("busy_released", int'(busy), 0);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, obs_line.size(), exp_line.size());
        for (int i = 0; i < exp_line.size() && i < obs_line.size(); i++) begin
            chk($sformatf("%s_line[%0d]", tag, i), obs_line[i], exp_line[i]);
            chk($sformatf("%s_done[%0d]", tag, i), obs_fd[i], exp_fd[i]);
            chk($sformatf("%s_under[%0d]", tag, i), obs_ur[i], exp_ur[i]);
        end
    endtask

    task automatic run_check(input string tag);
        fork
            drive_all();
            capture();
        join
        chk({tag, "_start"}, first_busy, first_acc + 1);
        compare(tag);
    endtask

    initial begin
        int n, acc2, nw, ab, e;
        logic [7:0] w;

        vecs[0] = '{8'hA5, 16'h9966};
        vecs[1] = '{8'h00, 16'h5555};
        vecs[2] = '{8'hFF, 16'hAAAA};
        vecs[3] = '{8'h3C, 16'h5AA5};

        aresetn = 1'b0; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0;
        d2_tdata = 8'h00; d2_tvalid = 1'b0; d2_tlast = 1'b0;
        clear_all();
        #12;
        chk("rst_serial", int'(serial_out), 0);
        chk("rst_ready", int'(tready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_under", int'(underrun), 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        chk("ready_before_edge", int'(tready), 0);
        @(negedge aclk);
        chk("ready_after_edge", int'(tready), 1);
        chk("d2_ready_after_edge", int'(d2_tready), 1);

        // Single-word frames against hand-computed half-bit constants.
        for (int v = 0; v < 4; v++) begin
            clear_all();
            word_q.push_back(vecs[v].data);
            last_q.push_back(1'b1);
            model_preamble();
            model_word(int'(vecs[v].data), 8, 1, 1);
            model_gap(GAPC, 0);
            run_check($sformatf("tbl%0d", v));
            chk($sformatf("tbl%0d_busy_cycles", v), obs_line.size(), 52);
            chk($sformatf("tbl%0d_done_at_52", v), obs_fd[51], 1);
            for (int k = 0; k < 16; k++) begin
                e = int'((vecs[v].halves >> (15 - k)) & 16'd1) ^ IEEE;
                chk($sformatf("tbl%0d_data[%0d]", v, k), obs_line[32 + k], e);
            end
        end

        // Back-to-back words stream with no idle cycles; ready opens once per boundary then stays open.
        clear_all();
        word_q = '{8'h01, 8'h02, 8'hFF};
        last_q = '{1'b0, 1'b0, 1'b1};
        model_preamble();
        model_word('h01, 8, 1, 1);
        model_word('h02, 8, 1, 1);
        model_word('hFF, 8, 1, 1);
        model_gap(GAPC, 0);
        run_check("stream");
        chk("stream_ready_cycles", rdy_cnt, 22);

        // Starvation mid-frame.
        clear_all();
        word_q.push_back(8'h00);
        last_q.push_back(1'b0);
        model_preamble();
        model_word('h00, 8, 1, 1);
        model_gap(GAPC, 1);
        run_check("underrun");

        // Next frame queued before the gap ends starts straight after it.
        clear_all();
        word_q = '{8'hA5, 8'h3C};
        last_q = '{1'b1, 1'b1};
        model_preamble();
        model_word('hA5, 8, 1, 1);
        model_gap(GAPC, 0);
        model_preamble();
        model_word('h3C, 8, 1, 1);
        model_gap(GAPC, 0);
        run_check("bypass");

        // Reset in the middle of the data word.
        clear_all();
        word_q.push_back(8'hC3);
        last_q.push_back(1'b1);
        drive_all();
        repeat (40) @(negedge aclk);
        chk("mid_busy", int'(busy), 1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_serial", int'(serial_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(tready), 0);
        chk("mid_rst_done", int'(frame_done), 0);
        @(negedge aclk);
        chk("mid_rst_done_hold", int'(frame_done), 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_rst_ready_back", int'(tready), 1);
        clear_all();
        word_q.push_back(8'h81);
        last_q.push_back(1'b1);
        model_preamble();
        model_word('h81, 8, 1, 1);
        model_gap(GAPC, 0);
        run_check("post_reset");

        // Slow LSB-first instance with no preamble.
        clear_all();
        d2_tdata = 8'h01; d2_tlast = 1'b1; d2_tvalid = 1'b1;
        n = 0;
        while (!d2_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        acc2 = cyc + 1;
        @(negedge aclk);
        d2_tvalid = 1'b0;
        n = 0;
        while (!d2_busy && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("h3_start", cyc, acc2 + 1);
        while (d2_busy && n < 500) begin
            obs_line.push_back(int'(d2_serial));
            obs_fd.push_back(int'(d2_done));
            obs_ur.push_back(int'(d2_under));
            @(negedge aclk);
            n++;
        end
        chk("h3_busy_released", int'(d2_busy), 0);
        model_word('h01, 8, 0, 3);
        model_gap(12, 0);
        chk("h3_frame_cycles", obs_line.size(), 60);
        for (int k = 0; k < 6; k++) chk($sformatf("h3_first_bit[%0d]", k), obs_line[k], ((k < 3) ? 1 : 0) ^ IEEE);
        compare("h3");

        // Randomized frames, some deliberately starved.
        for (int f = 0; f < 6; f++) begin
            clear_all();
            nw = int'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? 1 : 0;
            model_preamble();
            for (int i = 0; i < nw; i++) begin
                w = 8'($urandom);
                word_q.push_back(w);
                last_q.push_back((ab == 0 && i == nw - 1) ? 1'b1 : 1'b0);
                model_word(int'(w), 8, 1, 1);
            end
            model_gap(GAPC, ab);
            run_check($sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
